execute_stage: RTL and testbench

- Y86-64 execute stage. Sits directly downstream of decode/writeback.
- Takes decoded icode/ifun/rA/rB/valA/valB/valC and computes valE through the ALU.
- Holds the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovxx/jxx.
- Registers results into a one-entry E/M output register with a valid/ready handshake. Memory and writeback consume it; dstE/dstM are routed back to decode for writeback.

---
 rtl/execute_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_execute_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, Cnd evaluation and a one-entry E/M output register.
// Optional retired-instruction counter enabled by defining EXE_PERF_CNT_EN.
module execute_stage #(
  parameter int         W      = 64,
  parameter logic [3:0] SP_REG = 4'h4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   e_icode,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic         e_cnd,
  output logic [1:0]   e_stat,
  output logic [2:0]   cc
`ifdef EXE_PERF_CNT_EN
  ,
  output logic [31:0]  retired_cnt
`endif
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_HLT    = 2'd1;
  localparam logic [1:0] S_INS    = 2'd2;
  localparam logic signed [W-1:0] EIGHT = W'(8);

  logic         out_valid_q, out_valid_d;
  logic [3:0]   e_icode_q, e_icode_d;
  logic [W-1:0] e_val_e_q, e_val_e_d;
  logic [W-1:0] e_val_a_q, e_val_a_d;
  logic [3:0]   e_dst_e_q, e_dst_e_d;
  logic [3:0]   e_dst_m_q, e_dst_m_d;
  logic         e_cnd_q, e_cnd_d;
  logic [1:0]   e_stat_q, e_stat_d;
  logic [2:0]   cc_q, cc_d;
  logic         halted_q, halted_d;

  logic signed [W-1:0] op_a, op_b, op_c, alu_t;
  logic         zf_c, sf_c, of_c;
  logic         cnd_c;
  logic [3:0]   dst_e_c, dst_m_c;
  logic [1:0]   stat_c;
  logic         accept;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, sf, of;
    {zf, sf, of} = flags;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !(sf ^ of);
      4'd6:    return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  assign op_a     = valA;
  assign op_b     = valB;
  assign op_c     = valC;
  assign in_ready = !halted_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // ALU and flag generation for the instruction presented this cycle
  always_comb begin
    alu_t = '0;
    of_c  = 1'b0;
    case (icode)
      I_RRMOVQ:          alu_t = op_a;
      I_IRMOVQ:          alu_t = op_c;
      I_RMMOVQ, I_MRMOVQ: alu_t = op_b + op_c;
      I_CALL, I_PUSHQ:   alu_t = op_b - EIGHT;
      I_RET, I_POPQ:     alu_t = op_b + EIGHT;
      I_OPQ: begin
        case (ifun)
          4'd0: begin
            alu_t = op_b + op_a;
            of_c  = (op_a[W-1] == op_b[W-1]) && (alu_t[W-1] != op_a[W-1]);
          end
          4'd1: begin
            alu_t = op_b - op_a;
            of_c  = (op_b[W-1] != op_a[W-1]) && (alu_t[W-1] != op_b[W-1]);
          end
          4'd2:    alu_t = op_b & op_a;
          4'd3:    alu_t = op_b ^ op_a;
          default: alu_t = '0;
        endcase
      end
      default:           alu_t = '0;
    endcase
    zf_c = (alu_t == '0);
    sf_c = alu_t[W-1];
  end

  // Condition, destinations and status; Cnd sees the flags from before this edge
  always_comb begin
    cnd_c   = 1'b1;
    dst_e_c = R_NONE;
    dst_m_c = R_NONE;
    stat_c  = S_AOK;
    if (icode == I_RRMOVQ || icode == I_JXX) cnd_c = cond_eval(ifun, cc_q);
    case (icode)
      I_HALT:                           stat_c  = S_HLT;
      I_RRMOVQ:                         dst_e_c = cnd_c ? rB : R_NONE;
      I_IRMOVQ, I_OPQ:                  dst_e_c = rB;
      I_MRMOVQ:                         dst_m_c = rA;
      I_CALL, I_RET, I_PUSHQ:           dst_e_c = SP_REG;
      I_POPQ: begin
        dst_e_c = SP_REG;
        dst_m_c = rA;
      end
      I_NOP, I_RMMOVQ, I_JXX:           stat_c  = S_AOK;
      default:                          stat_c  = S_INS;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    e_icode_d   = e_icode_q;
    e_val_e_d   = e_val_e_q;
    e_val_a_d   = e_val_a_q;
    e_dst_e_d   = e_dst_e_q;
    e_dst_m_d   = e_dst_m_q;
    e_cnd_d     = e_cnd_q;
    e_stat_d    = e_stat_q;
    cc_d        = cc_q;
    halted_d    = halted_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      e_icode_d   = icode;
      e_val_e_d   = alu_t;
      e_val_a_d   = valA;
      e_dst_e_d   = dst_e_c;
      e_dst_m_d   = dst_m_c;
      e_cnd_d     = cnd_c;
      e_stat_d    = stat_c;
      if (icode == I_OPQ) cc_d = {zf_c, sf_c, of_c};
      if (stat_c != S_AOK) halted_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      e_icode_q   <= I_NOP;
      e_val_e_q   <= '0;
      e_val_a_q   <= '0;
      e_dst_e_q   <= R_NONE;
      e_dst_m_q   <= R_NONE;
      e_cnd_q     <= 1'b0;
      e_stat_q    <= S_AOK;
      cc_q        <= 3'b100;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      e_icode_q   <= e_icode_d;
      e_val_e_q   <= e_val_e_d;
      e_val_a_q   <= e_val_a_d;
      e_dst_e_q   <= e_dst_e_d;
      e_dst_m_q   <= e_dst_m_d;
      e_cnd_q     <= e_cnd_d;
      e_stat_q    <= e_stat_d;
      cc_q        <= cc_d;
      halted_q    <= halted_d;
    end
  end

`ifdef EXE_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (accept && stat_c == S_AOK) retired_cnt_d = retired_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_cnt_q <= '0;
    else        retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign e_icode   = e_icode_q;
  assign e_valE    = e_val_e_q;
  assign e_valA    = e_val_a_q;
  assign e_dstE    = e_dst_e_q;
  assign e_dstM    = e_dst_m_q;
  assign e_cnd     = e_cnd_q;
  assign e_stat    = e_stat_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, hand sequences and randomized traffic vs a reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  icode = 4'h1, ifun = 4'h0, rA = 4'hF, rB = 4'hF;
  logic [63:0] valA = '0, valB = '0, valC = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valA;
  logic        e_cnd;
  logic [1:0]  e_stat;
  logic [2:0]  cc;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  execute_stage #(.W(64), .SP_REG(4'h4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valA(valA), .valB(valB), .valC(valC), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .e_icode(e_icode), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_cnd(e_cnd), .e_stat(e_stat), .cc(cc)
`ifdef EXE_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic        m_valid, m_halted, m_cnd;
  logic [3:0]  m_icode, m_dste, m_dstm;
  logic [63:0] m_vale, m_vala;
  logic [1:0]  m_stat;
  logic [2:0]  m_cc;
  logic [31:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 0; m_halted = 0; m_cnd = 0; m_icode = 4'h1;
    m_dste = 4'hF; m_dstm = 4'hF; m_vale = '0; m_vala = '0;
    m_stat = 0; m_cc = 3'b100; m_cnt = 0;
  endtask

  function automatic logic m_ready();
    return !m_halted && (!m_valid || out_ready);
  endfunction

  task automatic model_edge();
    logic acc, cnd, zf, sf, of, nof;
    logic [63:0] t;
    logic signed [64:0] wide;
    logic [3:0] de, dm;
    logic [1:0] st;
    acc = in_valid && m_ready() && !flush;
    if (flush) m_valid = 0;
    else if (acc) begin
      {zf, sf, of} = m_cc;
      cnd = 1;
      if (icode == 2 || icode == 7)
        case (ifun)
          0: cnd = 1;
          1: cnd = (sf != of) || zf;
          2: cnd = (sf != of);
          3: cnd = zf;
          4: cnd = !zf;
          5: cnd = (sf == of);
          6: cnd = (sf == of) && !zf;
          default: cnd = 0;
        endcase
      t = 0; de = 4'hF; dm = 4'hF; nof = 0;
      st = (icode == 0) ? 2'd1 : (icode > 11) ? 2'd2 : 2'd0;
      case (icode)
        2: begin t = valA; if (cnd) de = rB; end
        3: begin t = valC; de = rB; end
        4: t = valB + valC;
        5: begin t = valB + valC; dm = rA; end
        6: begin
          de = rB;
          case (ifun)
            0: begin wide = $signed({valB[63], valB}) + $signed({valA[63], valA}); t = wide[63:0]; nof = wide[64] != wide[63]; end
            1: begin wide = $signed({valB[63], valB}) - $signed({valA[63], valA}); t = wide[63:0]; nof = wide[64] != wide[63]; end
            2: t = valB & valA;
            default: t = valB ^ valA;
          endcase
          m_cc = {t == 0, t[63], nof};
        end
        8, 10: begin t = valB - 8; de = 4'h4; end
        9: begin t = valB + 8; de = 4'h4; end
        11: begin t = valB + 8; de = 4'h4; dm = rA; end
        default: t = 0;
      endcase
      if (st != 0) m_halted = 1;
      else m_cnt++;
      m_valid = 1; m_icode = icode; m_vale = t; m_vala = valA;
      m_dste = de; m_dstm = dm; m_cnd = cnd; m_stat = st;
    end else if (out_ready) m_valid = 0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("e_icode", e_icode, m_icode);
    chk("e_valE", e_valE, m_vale);
    chk("e_valA", e_valA, m_vala);
    chk("e_dstE", e_dstE, m_dste);
    chk("e_dstM", e_dstM, m_dstm);
    chk("e_cnd", e_cnd, m_cnd);
    chk("e_stat", e_stat, m_stat);
    chk("cc", cc, m_cc);
`ifdef EXE_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_cnt);
`endif
  endtask

  task automatic step(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                      input logic fl, input logic ordy);
    @(negedge clk);
    in_valid = iv; icode = ic; ifun = fn; rA = ra; rB = rb;
    valA = va; valB = vb; valC = vc; flush = fl; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
    model_reset();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_e_icode", e_icode, 4'h1);
    chk("rst_e_valE", e_valE, 0);
    chk("rst_e_dstE", e_dstE, 4'hF);
    chk("rst_e_dstM", e_dstM, 4'hF);
    chk("rst_e_stat", e_stat, 0);
    chk("rst_cc", cc, 3'b100);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic iv; logic [3:0] ic, fn, ra, rb; logic [63:0] va, vb, vc; logic fl;
    logic ev; logic data; logic [63:0] evale; logic [3:0] edste, edstm;
    logic ecnd; logic [1:0] estat; logic [2:0] ecc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 4'h6, 4'h0, 4'h1, 4'h3, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1, 1, 64'h0, 4'h3, 4'hF, 1, 2'd0, 3'b100};
    tbl[1]  = '{1, 4'h6, 4'h1, 4'h1, 4'h5, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 0, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h5, 4'hF, 1, 2'd0, 3'b001};
    tbl[2]  = '{1, 4'h7, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 64'h40, 0, 1, 1, 64'h0, 4'hF, 4'hF, 1, 2'd0, 3'b001};
    tbl[3]  = '{1, 4'h2, 4'h3, 4'h1, 4'h2, 64'h1234, 64'h0, 64'h0, 0, 1, 1, 64'h1234, 4'hF, 4'hF, 0, 2'd0, 3'b001};
    tbl[4]  = '{1, 4'h6, 4'h3, 4'h1, 4'h6, 64'h55, 64'h55, 64'h0, 0, 1, 1, 64'h0, 4'h6, 4'hF, 1, 2'd0, 3'b100};
    tbl[5]  = '{1, 4'h2, 4'h3, 4'h1, 4'h2, 64'hABCD, 64'h0, 64'h0, 0, 1, 1, 64'hABCD, 4'h2, 4'hF, 1, 2'd0, 3'b100};
    tbl[6]  = '{1, 4'h3, 4'h0, 4'hF, 4'h7, 64'h0, 64'h0, 64'h42, 0, 1, 1, 64'h42, 4'h7, 4'hF, 1, 2'd0, 3'b100};
    tbl[7]  = '{1, 4'h5, 4'h0, 4'h8, 4'h9, 64'h0, 64'h100, 64'h10, 0, 1, 1, 64'h110, 4'hF, 4'h8, 1, 2'd0, 3'b100};
    tbl[8]  = '{1, 4'hB, 4'h0, 4'h3, 4'h4, 64'h0, 64'h200, 64'h0, 0, 1, 1, 64'h208, 4'h4, 4'h3, 1, 2'd0, 3'b100};
    tbl[9]  = '{1, 4'h8, 4'h0, 4'hF, 4'h4, 64'h0, 64'h300, 64'h999, 0, 1, 1, 64'h2F8, 4'h4, 4'hF, 1, 2'd0, 3'b100};
    tbl[10] = '{1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h1, 64'h1, 64'h0, 1, 0, 0, 64'h0, 4'h0, 4'h0, 0, 2'd0, 3'b100};
    tbl[11] = '{0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 4'h0, 4'h0, 0, 2'd0, 3'b100};

    model_reset();
    do_reset();

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].ic, tbl[i].fn, tbl[i].ra, tbl[i].rb,
           tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].fl, 1'b1);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_cc", i), cc, tbl[i].ecc);
      if (tbl[i].data) begin
        chk($sformatf("vec%0d_valE", i), e_valE, tbl[i].evale);
        chk($sformatf("vec%0d_dstE", i), e_dstE, tbl[i].edste);
        chk($sformatf("vec%0d_dstM", i), e_dstM, tbl[i].edstm);
        chk($sformatf("vec%0d_cnd", i), e_cnd, tbl[i].ecnd);
        chk($sformatf("vec%0d_stat", i), e_stat, tbl[i].estat);
      end
    end

    // backpressure holds the pushq result and refuses the next input
    step(1, 4'hA, 4'h0, 4'hF, 4'h4, 64'h0, 64'h100, 64'h0, 0, 1);
    chk("push_valE", e_valE, 64'hF8);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h6, 4'h0, 4'h1, 4'h3, 64'h5, 64'h6, 64'h0, 0, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valE", e_valE, 64'hF8);
      chk("stall_dstE", e_dstE, 4'h4);
      chk("stall_valid", out_valid, 1);
    end
    step(1, 4'h6, 4'h0, 4'h1, 4'h3, 64'h5, 64'h6, 64'h0, 0, 1);
    chk("resume_valE", e_valE, 64'hB);
    chk("resume_dstE", e_dstE, 4'h3);
    step(0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 1, 0);
    chk("flush_stalled_valid", out_valid, 0);

    // halt locks the stage until reset, even across flush
    step(1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 0, 1);
    chk("halt_stat", e_stat, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, (i == 1), 1);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_stat_hold", e_stat, 2'd1);
    end

    // invalid icode after an OPq that moved the flags
    do_reset();
    step(1, 4'h6, 4'h1, 4'h1, 4'h2, 64'h1, 64'h5, 64'h0, 0, 1);
    chk("pre_ins_cc", cc, 3'b000);
    step(1, 4'hC, 4'h1, 4'h1, 4'h2, 64'h9, 64'h9, 64'h3, 0, 1);
    chk("ins_stat", e_stat, 2'd2);
    chk("ins_dstE", e_dstE, 4'hF);
    chk("ins_cc", cc, 3'b000);
    chk("ins_in_ready", in_ready, 0);
`ifdef EXE_PERF_CNT_EN
    chk("ins_cnt", retired_cnt, 32'd1);
`endif

    // asynchronous reset between clock edges
    do_reset();
    step(1, 4'hA, 4'h0, 4'hF, 4'h4, 64'h0, 64'h100, 64'h0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_valE", e_valE, 0);
    chk("async_dstE", e_dstE, 4'hF);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ic, fn;
      logic [63:0] va, vb;
      int r;
      if (m_halted) do_reset();
      r = $urandom_range(0, 99);
      if (r < 2) ic = 4'h0;
      else if (r < 4) ic = 4'(12 + $urandom_range(0, 3));
      else ic = 4'($urandom_range(1, 11));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      va = {$urandom, $urandom};
      vb = ($urandom_range(0, 4) == 0) ? va : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) va = {va[63], 63'($urandom_range(0, 3))};
      step($urandom_range(0, 9) < 8, ic, fn, 4'($urandom), 4'($urandom), va, vb,
           {$urandom, $urandom}, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
